// File: rtl/encoder_output_serializer.sv
// Drains the encoder's three sub-block FIFOs as q0,q1,q2 byte triplets over a valid/ready port.
// Define SERIALIZER_CHECKSUM_EN to append a running-XOR trailer byte to each block.
module encoder_output_serializer (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       code_block_length,
  input  logic       empty,
  input  logic [7:0] q0,
  input  logic [7:0] q1,
  input  logic [7:0] q2,
  output logic       rdreq_subblock,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       blk_done
);
  typedef enum logic [2:0] {
    IDLE, FETCH, CAPTURE, SEND0, SEND1, SEND2,
`ifdef SERIALIZER_CHECKSUM_EN
    CHK,
`endif
    DONE
  } state_t;

  typedef struct packed {
    logic [7:0] b2;
    logic [7:0] b1;
    logic [7:0] b0;
  } trip_t;

  state_t     st, nxt;
  logic       len_q;
  logic [9:0] cnt;
  trip_t      hold;
  logic       last_trip;

  // cnt holds the index of the triplet currently being sent
  assign last_trip = len_q ? (cnt == 10'd767) : (cnt == 10'd131);

`ifdef SERIALIZER_CHECKSUM_EN
  logic [7:0] csum;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) csum <= 8'h00;
    else if (st == IDLE && start) csum <= 8'h00;
    else if ((st == SEND0 || st == SEND1 || st == SEND2) && out_ready) csum <= csum ^ out_data;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st    <= IDLE;
      len_q <= 1'b0;
      cnt   <= 10'd0;
      hold  <= '0;
    end else begin
      st <= nxt;
      if (st == IDLE && start) begin
        len_q <= code_block_length;
        cnt   <= 10'd0;
      end
      if (st == CAPTURE) hold <= {q2, q1, q0};
      if (st == SEND2 && out_ready) cnt <= cnt + 10'd1;
    end
  end

  always_comb begin
    nxt            = st;
    rdreq_subblock = 1'b0;
    out_valid      = 1'b0;
    out_data       = 8'h00;
    case (st)
      IDLE:    if (start) nxt = FETCH;
      FETCH:   if (!empty) begin
                 rdreq_subblock = 1'b1;
                 nxt            = CAPTURE;
               end
      CAPTURE: nxt = SEND0;
      SEND0:   begin
                 out_valid = 1'b1;
                 out_data  = hold.b0;
                 if (out_ready) nxt = SEND1;
               end
      SEND1:   begin
                 out_valid = 1'b1;
                 out_data  = hold.b1;
                 if (out_ready) nxt = SEND2;
               end
      SEND2:   begin
                 out_valid = 1'b1;
                 out_data  = hold.b2;
                 if (out_ready) begin
`ifdef SERIALIZER_CHECKSUM_EN
                   nxt = last_trip ? CHK : FETCH;
`else
                   nxt = last_trip ? DONE : FETCH;
`endif
                 end
               end
`ifdef SERIALIZER_CHECKSUM_EN
      CHK:     begin
                 out_valid = 1'b1;
                 out_data  = csum;
                 if (out_ready) nxt = DONE;
               end
`endif
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign busy     = (st != IDLE) && (st != DONE);
  assign blk_done = (st == DONE);
endmodule
